// File: rtl/uart_tx_arb_if.sv
// Two-channel source side plus UART transmitter side of the frame arbiter.
//   master : the environment (two word sources and the UART transmitter model)
//   slave  : the arbiter itself
// Per channel: data/vld/last in, ack/gnt out. UART: tx_data/tx_vld out, tx_done in.
// Status: busy (any state but idle), err_to (tx_done timeout pulse).
interface uart_tx_arb_if;
  logic [15:0] ch0_data;
  logic [15:0] ch1_data;
  logic        ch0_vld;
  logic        ch1_vld;
  logic        ch0_last;
  logic        ch1_last;
  logic        ch0_ack;
  logic        ch1_ack;
  logic        ch0_gnt;
  logic        ch1_gnt;
  logic [15:0] tx_data;
  logic        tx_vld;
  logic        tx_done;
  logic        busy;
  logic        err_to;

  modport master (
    output ch0_data, ch1_data, ch0_vld, ch1_vld, ch0_last, ch1_last, tx_done,
    input  ch0_ack, ch1_ack, ch0_gnt, ch1_gnt, tx_data, tx_vld, busy, err_to
  );

  modport slave (
    input  ch0_data, ch1_data, ch0_vld, ch1_vld, ch0_last, ch1_last, tx_done,
    output ch0_ack, ch1_ack, ch0_gnt, ch1_gnt, tx_data, tx_vld, busy, err_to
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets one of two word sources own a UART transmitter for a
// whole frame. Each frame is a header word (HDR_WORD with bit0 = channel index)
// followed by data words until the source flags last or MAX_LEN words are sent.
// Exactly one word is ever outstanding at the UART; a missing tx_done for TO_CYC
// cycles abandons the frame with an err_to pulse.
// Ports:
//   clk_sys : system clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : uart_tx_arb_if.slave (sources, UART, status)
module uart_tx_arb #(
  parameter logic [15:0] HDR_WORD = 16'hA5A0,
  parameter logic [19:0] MAX_LEN  = 20'd4000,
  parameter logic [19:0] TO_CYC   = 20'd100000
) (
  input  logic          clk_sys,
  input  logic          rst,
  uart_tx_arb_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StHdr, StHwait, StData, StDwait, StDone} state_e;

  state_e      state_q, state_d;
  logic        gnt_idx_q, gnt_idx_d;
  logic        rr_q;        // channel served last; ties go to the other one
  logic        last_q;
  logic [19:0] word_cnt_q;
  logic [19:0] to_cnt_q;
  logic [15:0] tx_data_q;
  logic        tx_vld_q;

  logic        req_vld;
  logic        req_last;
  logic [15:0] req_data;
  logic        arb_idx;
  logic        in_wait;
  logic        timeout;
  logic        launch;
  logic        word_done;
  logic        frame_end;

  assign req_vld  = gnt_idx_q ? bus.ch1_vld  : bus.ch0_vld;
  assign req_last = gnt_idx_q ? bus.ch1_last : bus.ch0_last;
  assign req_data = gnt_idx_q ? bus.ch1_data : bus.ch0_data;

  // Both requesting: pick the one not served last; otherwise whoever is asking.
  assign arb_idx = (bus.ch0_vld && bus.ch1_vld) ? ~rr_q : bus.ch1_vld;

  assign in_wait   = (state_q == StHwait) || (state_q == StDwait);
  // tx_done in the terminal cycle wins over the timeout.
  assign timeout   = in_wait && !tx_vld_q && !bus.tx_done && (to_cnt_q == TO_CYC - 20'd1);
  assign launch    = (state_q == StData) && req_vld;
  assign word_done = (state_q == StDwait) && bus.tx_done;
  assign frame_end = last_q || (word_cnt_q + 20'd1 == MAX_LEN);

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_idx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Next-state logic; the grant only changes when leaving idle.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ch0_vld || bus.ch1_vld) begin
          state_d   = StHdr;
          gnt_idx_d = arb_idx;
        end
      end
      StHdr: state_d = StHwait;
      StHwait: begin
        if (bus.tx_done)  state_d = StData;
        else if (timeout) state_d = StDone;
      end
      StData: begin
        if (req_vld) state_d = StDwait;
      end
      StDwait: begin
        if (bus.tx_done)  state_d = frame_end ? StDone : StData;
        else if (timeout) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: launch register, counters, round-robin pointer
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      tx_vld_q   <= 1'b0;
      tx_data_q  <= 16'h0;
      last_q     <= 1'b0;
      word_cnt_q <= 20'd0;
      to_cnt_q   <= 20'd0;
      rr_q       <= 1'b1;  // "ch1 served last" so ch0 wins the first tie
    end else begin
      tx_vld_q <= 1'b0;
      if (state_q == StHdr) begin
        tx_vld_q  <= 1'b1;
        tx_data_q <= {HDR_WORD[15:1], gnt_idx_q};
      end else if (launch) begin
        tx_vld_q  <= 1'b1;
        tx_data_q <= req_data;
        last_q    <= req_last;
      end

      if (word_done)               word_cnt_q <= word_cnt_q + 20'd1;
      else if (state_q == StDone)  word_cnt_q <= 20'd0;

      // Held at zero through the launch cycle, then counts waiting cycles.
      if (in_wait && !tx_vld_q) to_cnt_q <= to_cnt_q + 20'd1;
      else                      to_cnt_q <= 20'd0;

      if (state_q == StDone) rr_q <= gnt_idx_q;
    end
  end

  // Outputs
  always_comb begin
    bus.busy    = (state_q != StIdle);
    bus.ch0_gnt = (state_q != StIdle) && !gnt_idx_q;
    bus.ch1_gnt = (state_q != StIdle) &&  gnt_idx_q;
    bus.ch0_ack = word_done && !gnt_idx_q && !rst;
    bus.ch1_ack = word_done &&  gnt_idx_q && !rst;
    bus.err_to  = timeout && !rst;
    bus.tx_data = tx_data_q;
    bus.tx_vld  = tx_vld_q;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter HDR_WORD, 16'hA5A0, header word sent before each frame; bit0 is replaced by the granted channel index.
REQ-002 Parameter MAX_LEN, 20'd4000, maximum data words per frame (forced frame end).
REQ-003 Parameter TO_CYC, 20'd100000, clk_sys cycles to wait for tx_done before abort.
REQ-004 clk_sys  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ch0_data / ch1_data  input  16  source word, held stable while the matching vld is high.
REQ-007 ch0_vld / ch1_vld  input  1  source word valid, held high until the matching ack.
REQ-008 ch0_last / ch1_last  input  1  qualifies the current word as the last of its frame.
REQ-009 ch0_ack / ch1_ack  output  1  one-cycle pulse: current word consumed by the UART.
REQ-010 ch0_gnt / ch1_gnt  output  1  level: channel owns the UART for the current frame.
REQ-011 tx_data  output  16  word to the UART transmitter, registered.
REQ-012 tx_vld  output  1  one-cycle launch pulse to the UART transmitter.
REQ-013 tx_done  input  1  one-cycle pulse from the UART: word transmitted.
REQ-014 busy  output  1  high in every state except S_IDLE.
REQ-015 err_to  output  1  one-cycle pulse on tx_done timeout.

Function
REQ-016 FSM states: S_IDLE, S_HDR, S_HWAIT, S_DATA, S_DWAIT, S_DONE.
REQ-017 S_IDLE: when any chN_vld is high, grant one channel and go to S_HDR next cycle; otherwise stay.
REQ-018 Arbitration: round-robin, rr pointer; on simultaneous requests the channel != last-served wins; after reset ch0 has priority.
REQ-019 Grant latches on leaving S_IDLE and is held, without preemption, until S_DONE completes.
REQ-020 S_HDR: one cycle; tx_data <= {HDR_WORD[15:1], gnt_idx}, tx_vld pulse; go to S_HWAIT.
REQ-021 S_HWAIT: on tx_done go to S_DATA.
REQ-022 S_DATA: when granted chN_vld is high, tx_data <= chN_data, tx_vld pulse, capture last flag, go to S_DWAIT; otherwise wait with no timeout.
REQ-023 S_DWAIT: on tx_done, pulse chN_ack for one cycle and increment the 20-bit word counter.
REQ-024 S_DWAIT exit: if the captured last flag is set or the counter reaches MAX_LEN, go to S_DONE; otherwise go to S_DATA.
REQ-025 S_DONE: one cycle; drop grant, set rr pointer to the served channel, clear the word counter, go to S_IDLE.
REQ-026 The ungranted channel's ack is never asserted; its vld is ignored until arbitration.
REQ-027 Exactly one word is outstanding: tx_vld is never re-asserted before tx_done for the previous word.
REQ-028 tx_done in S_IDLE, S_HDR, S_DATA or S_DONE is ignored.
REQ-029 Timeout counter (20-bit): clears on each tx_vld pulse and counts in S_HWAIT/S_DWAIT.
REQ-030 On timeout count == TO_CYC-1 without tx_done: pulse err_to, no ack, go to S_DONE (frame abandoned).
REQ-031 tx_done arriving in the same cycle as the timeout terminal count takes precedence (normal completion, no err_to).
REQ-032 A source may start a new frame (vld high) on the cycle after ack; it is served after S_DONE/S_IDLE arbitration.

Reset
REQ-033 While rst is high on a clock edge, the block SHALL enter S_IDLE: tx_vld=0, tx_data=16'h0, all ack=0, all gnt=0, busy=0, err_to=0, counters=0, rr pointer favouring ch0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no ack or tx_vld in the following cycle.

Verification
REQ-035 ch0 only, 3 words 16'h0011/0022/0033 (last on third), tx_done 5 cycles after each tx_vld -> tx_data A5A0,0011,0022,0033; 3 ch0_ack; busy falls after S_DONE.
REQ-036 ch0 and ch1 vld together after reset, 1-word frames -> ch0 frame (header A5A0) first, then ch1 (header A5A1); repeating with both requesting again yields ch0 next (alternation).
REQ-037 ch1 requests during a long ch0 frame -> no ch1_ack/gnt until ch0 S_DONE; ch1 served next.
REQ-038 tx_done withheld after the second data word, TO_CYC=16 -> err_to pulse 16 cycles after tx_vld, no ack for that word, grant dropped, IDLE.
REQ-039 MAX_LEN=4, source never asserts last -> frame ends after 4 acks; a fifth word starts a new frame with a fresh header.
REQ-040 rst pulsed while in S_DWAIT, then a late tx_done -> outputs at reset values, tx_done ignored, next request starts with the ch0-priority rule.
